// File: rtl/sisc_pkg.sv
// sisc_pkg: SISC opcode constants, IR field positions and fetch FSM state encodings.
package sisc_pkg;
  typedef enum logic [3:0] {
    NOOP = 4'h0,
    LOD  = 4'h1,
    STR  = 4'h2,
    ADD  = 4'h3,
    CMP  = 4'h4,
    SHF  = 4'h5,
    ROT  = 4'h6,
    XOR  = 4'h7,
    BRA  = 4'h8,
    BRR  = 4'h9,
    HLT  = 4'hF
  } opcode_e;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int MM_MSB  = 27;
  localparam int MM_LSB  = 24;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_FULL = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/sisc_pc_gen.sv
// sisc_pc_gen: program counter register with relative/absolute branch target computation.
module sisc_pc_gen #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_rst_i,
  input  logic          pc_write_i,
  input  logic          pc_sel_i,
  input  logic          br_sel_i,
  input  logic [15:0]   imm_i,
  output logic [AW-1:0] pc_o
);
  logic [AW-1:0] pc_q, pc_d, pc_inc, br_addr;
  always_comb begin
    pc_inc  = pc_q + AW'(1);
    br_addr = br_sel_i ? AW'(imm_i) : pc_inc + AW'(imm_i);
    pc_d    = pc_rst_i ? '0 : pc_write_i ? (pc_sel_i ? br_addr : pc_inc) : pc_q;
  end
  always_ff @(posedge clk) pc_q <= rst ? '0 : pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: PC/IR holder with single-word instruction prefetch over req/ack.
// Optional FETCH_STALL_CNT_EN adds a saturating stall-cycle counter.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_rst,
  input  logic          pc_write,
  input  logic          pc_sel,
  input  logic          br_sel,
  input  logic          ir_load,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [15:0]   imm,
  output logic [AW-1:0] pc_out,
  output logic          stall,
  output logic [15:0]   stall_cnt
);
  fetch_state_e  state_q, state_d;
  logic          flush_q, flush_d, redirect;
  logic [DW-1:0] buf_q, buf_d, ir_q, ir_d;
  logic [AW-1:0] addr_q, addr_d;
  sisc_pc_gen #(.AW(AW)) u_pc_gen (
    .clk       (clk),
    .rst       (rst),
    .pc_rst_i  (pc_rst),
    .pc_write_i(pc_write),
    .pc_sel_i  (pc_sel),
    .br_sel_i  (br_sel),
    .imm_i     (imm),
    .pc_o      (pc_out)
  );
  // A redirect during an outstanding request cannot abort the bus, so it is remembered as a flush.
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    buf_d    = buf_q;
    ir_d     = ir_q;
    addr_d   = addr_q;
    redirect = pc_rst | pc_write;
    case (state_q)
      F_IDLE: begin
        state_d = redirect ? F_IDLE : F_REQ;
        addr_d  = redirect ? addr_q : pc_out;
      end
      F_REQ: begin
        state_d = !imem_ack ? F_REQ : (flush_q | redirect) ? F_IDLE : F_FULL;
        flush_d = !imem_ack & (flush_q | redirect);
        buf_d   = imem_ack ? imem_rdata : buf_q;
      end
      F_FULL: begin
        ir_d    = ir_load ? buf_q : ir_q;
        state_d = (ir_load | redirect) ? F_IDLE : F_FULL;
      end
      default: state_d = F_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      flush_q <= 1'b0;
      buf_q   <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      buf_q   <= buf_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
    end
  end
  assign imem_req  = state_q == F_REQ;
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[OP_MSB:OP_LSB];
  assign mm        = ir_q[MM_MSB:MM_LSB];
  assign imm       = ir_q[IMM_MSB:IMM_LSB];
  assign stall     = ir_load & (state_q != F_FULL);
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst || pc_rst) cnt_q <= '0;
    else if (stall && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_sisc_fetch_unit.sv
// tb_sisc_fetch_unit: directed and randomized checks of sisc_fetch_unit against a flag-level model.
module tb_sisc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1, pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0;
  logic        ir_load = 1'b0, imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, stall;
  logic [15:0] imem_addr, pc_out, imm, stall_cnt;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;
  int checks = 0, errors = 0;

  sisc_fetch_unit #(.AW(16), .DW(32)) dut (
    .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .br_sel(br_sel), .ir_load(ir_load), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .ir(ir), .opcode(opcode), .mm(mm),
    .imm(imm), .pc_out(pc_out), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference: a request is either outstanding (possibly stale), or a word is buffered, or neither.
  logic [15:0] m_pc, m_addr, m_cnt;
  logic [31:0] m_ir, m_buf;
  logic        m_busy, m_stale, m_full;
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= '0; m_ir <= '0; m_buf <= '0; m_addr <= '0; m_cnt <= '0;
      m_busy <= 1'b0; m_stale <= 1'b0; m_full <= 1'b0;
    end else begin
      m_pc <= pc_rst ? 16'd0 : !pc_write ? m_pc : !pc_sel ? m_pc + 16'd1 :
              br_sel ? m_ir[15:0] : m_pc + 16'd1 + m_ir[15:0];
      if (m_busy) begin
        if (imem_ack) begin
          m_busy <= 1'b0; m_stale <= 1'b0;
          if (!(m_stale || pc_rst || pc_write)) begin m_full <= 1'b1; m_buf <= imem_rdata; end
        end else if (pc_rst || pc_write) m_stale <= 1'b1;
      end else if (m_full) begin
        if (ir_load) m_ir <= m_buf;
        if (ir_load || pc_rst || pc_write) m_full <= 1'b0;
      end else if (!(pc_rst || pc_write)) begin
        m_busy <= 1'b1; m_addr <= m_pc;
      end
`ifdef FETCH_STALL_CNT_EN
      if (pc_rst) m_cnt <= '0;
      else if (ir_load && !m_full && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
`endif
    end
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic fetch_load(input logic [31:0] w);
    int n = 0;
    while (!imem_req && n < 20) begin step(); n++; end
    checks++;
    if (!imem_req) begin errors++; $display("FAIL fetch_timeout req %b required 1", imem_req); end
    imem_ack = 1'b1; imem_rdata = w; step();
    imem_ack = 1'b0; ir_load = 1'b1; step();
    ir_load = 1'b0;
  endtask

  task automatic branch(input logic s, input logic b);
    pc_write = 1'b1; pc_sel = s; br_sel = b; step();
    pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; step(); step();
    @(negedge clk);
    checks += 5;
    if (pc_out !== 16'h0) begin errors++; $display("FAIL rst_pc got %h required 0000", pc_out); end
    if (ir !== 32'h0) begin errors++; $display("FAIL rst_ir got %h required 0", ir); end
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b required 0", imem_req); end
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b required 0", stall); end
    if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h required 0", stall_cnt); end
    rst = 1'b0; step();
    @(negedge clk);
    checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %b required 1", imem_req); end
    if (imem_addr !== 16'h0) begin errors++; $display("FAIL rel_addr got %h required 0000", imem_addr); end
  endtask

  task automatic test_fetch_load;
    imem_ack = 1'b1; imem_rdata = 32'h8800_0005; step();
    imem_ack = 1'b0;
    @(negedge clk);
    ir_load = 1'b1; #1;
    checks += 2;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got %b required 0", imem_req); end
    if (stall !== 1'b0) begin errors++; $display("FAIL full_stall got %b required 0", stall); end
    step(); ir_load = 1'b0;
    @(negedge clk);
    checks += 4;
    if (ir !== 32'h8800_0005) begin errors++; $display("FAIL load_ir got %h required 88000005", ir); end
    if (opcode !== 4'h8) begin errors++; $display("FAIL load_op got %h required 8", opcode); end
    if (mm !== 4'h8) begin errors++; $display("FAIL load_mm got %h required 8", mm); end
    if (imm !== 16'h0005) begin errors++; $display("FAIL load_imm got %h required 0005", imm); end
  endtask

  task automatic test_branch;
    fetch_load(32'h8000_0010); branch(1'b1, 1'b1);
    @(negedge clk); checks++;
    if (pc_out !== 16'h0010) begin errors++; $display("FAIL br_abs10 got %h required 0010", pc_out); end
    fetch_load(32'h8000_FFFE); branch(1'b1, 1'b0);
    @(negedge clk); checks++;
    if (pc_out !== 16'h000F) begin errors++; $display("FAIL br_rel got %h required 000F", pc_out); end
    branch(1'b1, 1'b1);
    @(negedge clk); checks++;
    if (pc_out !== 16'hFFFE) begin errors++; $display("FAIL br_abs got %h required FFFE", pc_out); end
  endtask

  task automatic test_flush;
    step();
    @(negedge clk); checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL fl_req0 got %b required 1", imem_req); end
    if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL fl_addr0 got %h required FFFE", imem_addr); end
    pc_write = 1'b1; step(); pc_write = 1'b0;
    step(); step();
    @(negedge clk); checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL fl_hold got %b required 1", imem_req); end
    if (imem_addr !== 16'hFFFE) begin errors++; $display("FAIL fl_stable got %h required FFFE", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 1'b0;
    @(negedge clk); checks += 2;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL fl_drop got %b required 0", imem_req); end
    if (ir !== 32'h8000_FFFE) begin errors++; $display("FAIL fl_ir got %h required 8000FFFE", ir); end
    step();
    @(negedge clk); checks += 2;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL fl_req1 got %b required 1", imem_req); end
    if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL fl_addr1 got %h required FFFF", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; step();
    imem_ack = 1'b0; ir_load = 1'b1; step(); ir_load = 1'b0;
    @(negedge clk); checks++;
    if (ir !== 32'h1234_5678) begin errors++; $display("FAIL fl_newir got %h required 12345678", ir); end
  endtask

  task automatic test_stall;
    logic [15:0] exp_cnt;
`ifdef FETCH_STALL_CNT_EN
    exp_cnt = 16'd4;
`else
    exp_cnt = 16'd0;
`endif
    pc_rst = 1'b1; step(); pc_rst = 1'b0;
    ir_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); checks += 2;
      if (stall !== 1'b1) begin errors++; $display("FAIL stall_%0d got %b required 1", i, stall); end
      if (ir !== 32'h1234_5678) begin errors++; $display("FAIL stall_ir_%0d got %h required 12345678", i, ir); end
      step();
    end
    ir_load = 1'b0;
    @(negedge clk); checks++;
    if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt got %0d required %0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_wrap;
    fetch_load(32'h0000_FFFF); branch(1'b1, 1'b1);
    @(negedge clk); checks++;
    if (pc_out !== 16'hFFFF) begin errors++; $display("FAIL wr_set got %h required FFFF", pc_out); end
    branch(1'b0, 1'b0);
    @(negedge clk); checks++;
    if (pc_out !== 16'h0000) begin errors++; $display("FAIL wr_inc got %h required 0000", pc_out); end
    branch(1'b1, 1'b1);
    pc_rst = 1'b1; pc_write = 1'b1; step(); pc_rst = 1'b0; pc_write = 1'b0;
    @(negedge clk); checks++;
    if (pc_out !== 16'h0000) begin errors++; $display("FAIL wr_pcrst got %h required 0000", pc_out); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom % 64) == 0;
      pc_rst   = ($urandom % 16) == 0;
      pc_write = ($urandom % 6) == 0;
      pc_sel   = 1'($urandom);
      br_sel   = 1'($urandom);
      ir_load  = ($urandom % 3) == 0;
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk); checks += 8;
      if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc c%0d got %h required %h", c, pc_out, m_pc); end
      if (ir !== m_ir) begin errors++; $display("FAIL rnd_ir c%0d got %h required %h", c, ir, m_ir); end
      if ({opcode, mm, imm} !== {m_ir[31:24], m_ir[15:0]}) begin
        errors++; $display("FAIL rnd_fields c%0d got %h %h %h required from %h", c, opcode, mm, imm, m_ir);
      end
      if (imem_req !== m_busy) begin errors++; $display("FAIL rnd_req c%0d got %b required %b", c, imem_req, m_busy); end
      if (m_busy && imem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr c%0d got %h required %h", c, imem_addr, m_addr); end
      if (stall !== (ir_load && !m_full)) begin errors++; $display("FAIL rnd_stall c%0d got %b required %b", c, stall, ir_load && !m_full); end
      if (stall_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt c%0d got %0d required %0d", c, stall_cnt, m_cnt); end
      if (m_full && imem_req !== 1'b0) begin errors++; $display("FAIL rnd_fullreq c%0d got %b required 0", c, imem_req); end
      step();
    end
    {rst, pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_ack} = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch_load();
    test_branch();
    test_flush();
    test_stall();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
